mem_io_ctrl: RTL
================

// Module: mem_io_ctrl
// PURPOSE
//  Memory-stage address decoder and MMIO unit downstream of the core datapath. Consumes the
//  E-stage address/wdata/byte-enables and routes them to DMEM or UART/counter registers.
//  Returns one-cycle-latent read data to the datapath for its M-stage data alignment.
//  Owns a 4-entry UART TX FIFO, RX pop handshake, and cycle/retired-instruction counters.
// PARAMETERS
//  TX_DEPTH   4   TX FIFO entries; power of two >= 2
//  XLEN       32  data/address width
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high
//  mem_adr      in   32    E-stage byte address; 0 means no access
//  mem_wdata    in   32    store data, already lane-shifted
//  wea          in   4     byte write enables; nonzero = store
//  mem_re       in   1     E-stage load strobe
//  instr_retire in   1     one instruction retired this cycle
//  din          out  32    read data, valid the cycle after the address
//  dmem_addr    out  14    DMEM word address = mem_adr[15:2]
//  dmem_wdata   out  32    = mem_wdata
//  dmem_we      out  4     = wea when the DMEM region is hit, else 0
//  dmem_dout    in   32    DMEM synchronous read data, 1-cycle latency
//  bios_dout    in   32    BIOS synchronous read data, 1-cycle latency
//  tx_data      out  8     UART TX byte (FIFO head)
//  tx_valid     out  1     FIFO not empty
//  tx_ready     in   1     UART accepts byte when tx_valid&tx_ready
//  rx_data      in   8     UART RX byte
//  rx_valid     in   1     RX byte available
//  rx_ready     out  1     one-cycle pop pulse to UART RX
// BEHAVIOUR
//  Map, mem_adr[31:28]: 0x1/0x3 DMEM; 0x4 BIOS (read-only); 0x8 MMIO; other regions: reads 0, writes ignored.
//  MMIO: 0x8000_0000 status RO {29'b0, tx_ovf, rx_valid, !fifo_full}; 0x8000_0004 RX data RO
//   (zero-extended; pops); 0x8000_0008 TX data WO (push mem_wdata[7:0]); 0x8000_0010 cycle_cnt RO;
//   0x8000_0014 instr_cnt RO; 0x8000_0018 WO: any store clears both counters and tx_ovf.
//  Read path: region select and MMIO read value are registered at the clock edge; din muxes
//   dmem_dout / bios_dout / registered MMIO value, one-cycle latency matching BRAM.
//  RX: load from 0x8000_0004 drives rx_ready=1 in that same cycle iff rx_valid; byte is captured
//   into the read register at that edge. Load when !rx_valid returns 0, no pulse.
//  TX FIFO: push on store to 0x8000_0008 with wea[0]; pop when tx_valid&tx_ready.
//   Full + push: byte dropped, tx_ovf set (sticky). Simultaneous push+pop at full: both occur,
//   no overflow. Empty: tx_valid=0, tx_data holds last value. Pointers wrap modulo TX_DEPTH.
//  Counters: 32-bit, wrap 0xFFFF_FFFF->0. cycle_cnt +1 every cycle; instr_cnt +1 on instr_retire.
//   Clear store has priority over increment in the same cycle (result 0).
//  Reset: din=0, rx_ready=0, tx_valid=0, tx_data=0, dmem_we=0, FIFO empty, counters 0, tx_ovf=0.
//   Reset mid-transfer drops FIFO contents; no held byte is re-sent.
//  Stores and loads in the same cycle: store takes effect, load read data is still returned.
// STRUCTURE
//  Address map constants (region nibbles, MMIO offsets) go in the shared defines.v.
//  Sub-module mmio_tx_fifo (sync FIFO: push/pop/full/empty/head) instantiated once.
//  Decode, counters, RX pop and read-data register stay in mem_io_ctrl.
// TESTING
//  Store 0xDEADBEEF wea=F to 0x1000_0010 -> dmem_we=F, dmem_addr=4; load next -> din=dmem_dout.
//  Push 5 bytes 0x41..0x45, tx_ready=0 -> status=0x4 after 5th (full, ovf); drain -> 0x41..0x44 only.
//  rx_valid=1, rx_data=0x5A, load 0x8000_0004 -> rx_ready 1 cycle, din=0x0000_005A next cycle.
//  Run 100 cycles with 37 retire pulses -> cycle_cnt=100, instr_cnt=37; store 0x8000_0018 -> both 0.
//  Force cycle_cnt=0xFFFF_FFFF -> next read 0; clear coincident with increment -> 0.
//  Assert reset with 3 FIFO entries pending -> tx_valid=0 next cycle, status=0x1.

Source files
------------

// File: rtl/mem_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_io_ctrl_pkg
// Brief  : Address map constants and read-select decode for mem_io_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_io_ctrl_pkg;

  localparam logic [3:0] C_REGION_DMEM_A = 4'h1;
  localparam logic [3:0] C_REGION_DMEM_B = 4'h3;
  localparam logic [3:0] C_REGION_BIOS   = 4'h4;
  localparam logic [3:0] C_REGION_MMIO   = 4'h8;

  localparam logic [27:0] C_MMIO_STATUS = 28'h000_0000;
  localparam logic [27:0] C_MMIO_RX     = 28'h000_0004;
  localparam logic [27:0] C_MMIO_TX     = 28'h000_0008;
  localparam logic [27:0] C_MMIO_CYCLE  = 28'h000_0010;
  localparam logic [27:0] C_MMIO_INSTR  = 28'h000_0014;
  localparam logic [27:0] C_MMIO_CLEAR  = 28'h000_0018;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DMEM = 2'd1,
    SEL_BIOS = 2'd2,
    SEL_MMIO = 2'd3
  } rd_sel_e;

  function automatic rd_sel_e region_sel(input logic [3:0] region);
    case (region)
      C_REGION_DMEM_A, C_REGION_DMEM_B: return SEL_DMEM;
      C_REGION_BIOS:                    return SEL_BIOS;
      C_REGION_MMIO:                    return SEL_MMIO;
      default:                          return SEL_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : mmio_tx_fifo
// Brief  : Synchronous FIFO for UART TX bytes; head holds the last byte when empty.
// Rev    : 1.0 - initial release
// ============================================================================
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int            C_AW   = $clog2(DEPTH);
  localparam logic [C_AW:0] C_FULL = (C_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_pop;
  logic             w_push;

  assign full   = (r_count == C_FULL);
  assign empty  = (r_count == '0);
  assign w_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle
  assign w_push = push && (!full || w_pop);
  assign head   = empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_io_ctrl
// Brief  : M-stage address decode, DMEM/BIOS routing, UART and counter MMIO.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_io_ctrl
  import mem_io_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] mem_adr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [3:0]      wea,
  input  logic            mem_re,
  input  logic            instr_retire,
  output logic [XLEN-1:0] din,
  output logic [13:0]     dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_we,
  input  logic [XLEN-1:0] dmem_dout,
  input  logic [XLEN-1:0] bios_dout,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready
);

  logic [3:0]      w_region;
  logic [27:0]     w_off;
  logic            w_access;
  logic            w_store;
  logic            w_load;
  logic            w_mmio;
  logic            w_tx_push;
  logic            w_tx_pop;
  logic            w_clear;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  rd_sel_e         w_sel;
  logic [XLEN-1:0] w_mmio_rdata;

  rd_sel_e         r_sel;
  logic [XLEN-1:0] r_mmio_rdata;
  logic [XLEN-1:0] r_cycle_cnt;
  logic [XLEN-1:0] r_instr_cnt;
  logic            r_tx_ovf;

  assign w_region  = mem_adr[31:28];
  assign w_off     = mem_adr[27:0];
  assign w_access  = |mem_adr;
  assign w_store   = w_access && |wea;
  assign w_load    = w_access && mem_re;
  assign w_mmio    = (w_region == C_REGION_MMIO);
  assign w_tx_push = w_store && w_mmio && (w_off == C_MMIO_TX) && wea[0];
  assign w_clear   = w_store && w_mmio && (w_off == C_MMIO_CLEAR);
  assign w_tx_pop  = tx_valid && tx_ready;
  assign w_sel     = w_load ? region_sel(w_region) : SEL_NONE;

  assign dmem_addr  = mem_adr[15:2];
  assign dmem_wdata = mem_wdata;
  assign dmem_we    = (!reset && region_sel(w_region) == SEL_DMEM && w_access) ? wea : 4'h0;
  assign rx_ready   = !reset && w_load && w_mmio && (w_off == C_MMIO_RX) && rx_valid;
  assign tx_valid   = !w_fifo_empty;

  mmio_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_tx_push),
    .push_data (mem_wdata[7:0]),
    .pop       (w_tx_pop),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (tx_data)
  );

  always_comb begin
    w_mmio_rdata = '0;
    case (w_off)
      C_MMIO_STATUS: w_mmio_rdata = {{(XLEN-3){1'b0}}, r_tx_ovf, rx_valid, !w_fifo_full};
      C_MMIO_RX:     if (rx_valid) w_mmio_rdata = {{(XLEN-8){1'b0}}, rx_data};
      C_MMIO_CYCLE:  w_mmio_rdata = r_cycle_cnt;
      C_MMIO_INSTR:  w_mmio_rdata = r_instr_cnt;
      default:       w_mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= SEL_NONE;
      r_mmio_rdata <= '0;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
      r_tx_ovf     <= 1'b0;
    end else begin
      r_sel <= w_sel;
      if (w_load && w_mmio) r_mmio_rdata <= w_mmio_rdata;
      // Clear wins over a coincident increment
      r_cycle_cnt <= w_clear ? '0 : r_cycle_cnt + 1'b1;
      if (w_clear)           r_instr_cnt <= '0;
      else if (instr_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
      if (w_clear)                                      r_tx_ovf <= 1'b0;
      else if (w_tx_push && w_fifo_full && !w_tx_pop)   r_tx_ovf <= 1'b1;
    end
  end

  // Read data follows the registered select so it lines up with BRAM latency
  always_comb begin
    din = '0;
    case (r_sel)
      SEL_DMEM: din = dmem_dout;
      SEL_BIOS: din = bios_dout;
      SEL_MMIO: din = r_mmio_rdata;
      default:  din = '0;
    endcase
  end

endmodule
`default_nettype wire
